des_result_serializer: RTL and testbench
========================================

# des_result_serializer

Downstream stage of the DES core wrapper: captures each 64-bit result when the DES core's result-valid pulse is asserted. Buffers up to two results and streams each result out as eight bytes over a four-phase req/ack pad handshake. The host side of the handshake is asynchronous. This stage replaces free-running byte rotation on the output pins with a lossless, flow-controlled transfer and exposes status for the wishbone STS register.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop depth of the pad_ack synchronizer (legal 2..4)
- LSB_FIRST, 1, 1 = byte 0 is data[7:0]; 0 = byte 0 is data[63:56]

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- i_dv  in  1  one-cycle result-valid from DES core
- i_data  in  64  DES result, sampled when i_dv=1
- i_clr_ovf  in  1  clears o_overflow
- pad_ack  in  1  host acknowledge, asynchronous to clk
- o_pad_req  out  1  byte request to host
- o_pad_data  out  8  current byte
- o_pad_last  out  1  high while byte 7 of a block is presented
- o_pad_parity  out  1  odd parity of o_pad_data (see Configuration)
- o_level  out  2  buffered results, 0..2 (includes block in flight)
- o_busy  out  1  FSM not in IDLE
- o_overflow  out  1  sticky: a result was dropped
- o_blocks_sent  out  16  completed blocks, wraps 0xFFFF->0

## Operation
- Two-entry FIFO of 64-bit results. Push occurs on i_dv when level<2. If i_dv arrives while level==2, the data is dropped and o_overflow is set. o_overflow stays set until i_clr_ovf or reset; if both are asserted in the same cycle as a drop, set wins.
- Pop occurs on completion of byte 7. A push and a pop in the same cycle at level 2 are both honoured: the push is accepted and level stays 2.
- pad_ack passes through a SYNC_STAGES-deep synchronizer to produce ack_s. No other use of raw pad_ack is allowed.
- FSM states:
  - IDLE: req=0. If level>0, load byte 0 of the head entry into o_pad_data and go to SETUP.
  - SETUP: req=0, data stable. After one cycle go to REQ_HI.
  - REQ_HI: req=1. When ack_s=1, go to REQ_LO.
  - REQ_LO: req=0. When ack_s=0:
    - if byte_idx==7: pop, increment o_blocks_sent, byte_idx=0, go to IDLE.
    - otherwise: byte_idx+1, load the next byte, go to SETUP.
- o_pad_data changes only on entry to SETUP; it is held constant from SETUP through REQ_LO.
- byte_idx is a 3-bit counter. Byte selection is data[8*idx+7:8*idx] when LSB_FIRST=1 and data[63-8*idx:56-8*idx] when LSB_FIRST=0.
- o_pad_last = (byte_idx==7) in SETUP, REQ_HI and REQ_LO; 0 in IDLE.
- Reset mid-transfer: at the next edge req=0, FIFO emptied, byte_idx=0, state IDLE. The partial block is discarded and not counted.

## Timing
- Reset values: o_pad_req=0, o_pad_data=0, o_pad_last=0, o_pad_parity=0 (when compiled out) or parity of 0x00 = 1 (when compiled in), o_level=0, o_busy=0, o_overflow=0, o_blocks_sent=0.
- i_dv sampled at edge N with FSM idle and empty:
  - o_level=1 after N
  - SETUP after N+1 (data valid)
  - o_pad_req=1 after N+2
- ack rise on the pin to req fall: SYNC_STAGES+1 cycles. Same latency for ack fall to the next SETUP.
- Minimum cycles per byte with instant host: 2*(SYNC_STAGES+1)+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- DES_SER_PARITY_EN defined: o_pad_parity is a registered value, XNOR-reduction of the byte (odd parity). It updates together with o_pad_data.
- DES_SER_PARITY_EN undefined: o_pad_parity is tied to 0 and no parity logic is built. The port list is unchanged.

## Structure
- Package des_ser_pkg contains: FSM state enum (IDLE, SETUP, REQ_HI, REQ_LO), BYTES_PER_BLOCK=8, DEPTH=2.
- Sub-module des_ser_fifo2 holds the two-entry 64-bit FIFO with push/pop/level/full. The synchronizer and FSM stay in the top module.

## Test plan
- Single block: i_dv with 0x0123456789ABCDEF, LSB_FIRST=1, host acks after 3 cycles. Expect bytes EF,CD,AB,89,67,45,23,01; o_pad_last only on 01; o_blocks_sent=1; o_level returns to 0.
- Order: LSB_FIRST=0, same data. Expect bytes 01..EF in order.
- Overflow: three i_dv pulses back-to-back while the host stalls ack. Expect level=2, o_overflow=1, and the first two blocks delivered intact. After i_clr_ovf, o_overflow=0.
- Push+pop collision: at level 2, i_dv coincides with the byte-7 ack-low completion. Expect level stays 2, no overflow, and the third block is delivered.
- Reset mid-transfer at byte 3 of a block. Expect req=0 the next cycle, level=0, o_blocks_sent unchanged; a subsequent block starts at byte 0.
- Parity (macro defined): byte 0x00 gives parity 1, byte 0x01 gives 0. Macro undefined: parity is always 0.

Source files
------------

// File: rtl/des_ser_pkg.sv
// des_ser_pkg: shared types and constants for the DES result serializer.
//   ser_state_e     - pad handshake FSM states
//   BYTES_PER_BLOCK - bytes streamed per 64-bit result
//   DEPTH           - result buffer depth
//   pick_byte()     - selects byte idx of a result in the configured order
package des_ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } ser_state_e;

  localparam int unsigned BYTES_PER_BLOCK = 8;
  localparam int unsigned DEPTH           = 2;
  localparam logic [2:0]  LAST_BYTE       = 3'(BYTES_PER_BLOCK - 1);

  // MSB-first order is the LSB-first slot mirrored: slot = 7 - idx = ~idx.
  function automatic logic [7:0] pick_byte(input logic [63:0] data,
                                           input logic [2:0]  idx,
                                           input logic        lsb_first);
    logic [2:0] slot;
    slot = lsb_first ? idx : ~idx;
    return data[{slot, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/des_ser_fifo2.sv
// des_ser_fifo2: two-entry 64-bit result FIFO.
//   clk, reset  - core clock, synchronous active-high reset
//   push_i      - write request; accepted when not full, or when full and
//                 popping in the same cycle
//   data_i      - result written on an accepted push
//   pop_i       - removes the head entry (ignored when empty)
//   head_o      - oldest entry
//   level_o     - number of entries held, 0..2
//   full_o      - level_o == DEPTH
module des_ser_fifo2
  import des_ser_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic [63:0] data_i,
  input  logic        pop_i,
  output logic [63:0] head_o,
  output logic [1:0]  level_o,
  output logic        full_o
);

  logic [63:0] mem_q [DEPTH];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  level_q;
  logic        accept;
  logic        pop_ok;

  assign full_o  = (level_q == 2'(DEPTH));
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];
  // When full, wr_ptr == rd_ptr: a simultaneous push overwrites the slot
  // being popped, which becomes the new tail once rd_ptr advances.
  assign accept  = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && (level_q != '0);

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      level_q  <= '0;
    end else begin
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      case ({accept, pop_ok})
        2'b10:   level_q <= level_q + 2'd1;
        2'b01:   level_q <= level_q - 2'd1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/des_result_serializer.sv
// des_result_serializer: buffers DES results (two deep) and streams each as
// eight bytes over a four-phase req/ack pad handshake.
//   clk, reset     - core clock, synchronous active-high reset
//   i_dv, i_data   - one-cycle result valid and 64-bit result
//   i_clr_ovf      - clears the sticky overflow flag (a same-cycle drop wins)
//   pad_ack        - asynchronous host acknowledge (synchronized internally)
//   o_pad_req      - byte request to host
//   o_pad_data     - current byte, stable from SETUP through REQ_LO
//   o_pad_last     - byte 7 of the block is presented
//   o_pad_parity   - odd parity of o_pad_data, built only when
//                    DES_SER_PARITY_EN is defined; otherwise tied to 0
//   o_level        - buffered results including the one in flight
//   o_busy         - FSM not idle
//   o_overflow     - sticky: a result was dropped
//   o_blocks_sent  - completed blocks, wrapping
// Parameters: SYNC_STAGES (2..4) pad_ack synchronizer depth;
//             LSB_FIRST 1 = data[7:0] first, 0 = data[63:56] first.
module des_result_serializer
  import des_ser_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          LSB_FIRST   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_dv,
  input  logic [63:0] i_data,
  input  logic        i_clr_ovf,
  input  logic        pad_ack,
  output logic        o_pad_req,
  output logic [7:0]  o_pad_data,
  output logic        o_pad_last,
  output logic        o_pad_parity,
  output logic [1:0]  o_level,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [15:0] o_blocks_sent
);

  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;

  ser_state_e  state_q, state_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  data_q, data_d;
  logic        req_q, last_q, busy_q;
  logic        ovf_q, ovf_d;
  logic [15:0] blocks_q, blocks_d;
  logic        pop;
  logic        drop;
  logic [63:0] head;
  logic [1:0]  level;
  logic        full;

  des_ser_fifo2 u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (i_dv),
    .data_i  (i_data),
    .pop_i   (pop),
    .head_o  (head),
    .level_o (level),
    .full_o  (full)
  );

  always_ff @(posedge clk) begin
    if (reset) ack_sync_q <= '0;
    else       ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], pad_ack};
  end
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  assign drop = i_dv && full && !pop;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    data_d     = data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (level != '0) begin
          byte_idx_d = '0;
          data_d     = pick_byte(head, 3'd0, LSB_FIRST);
          state_d    = SETUP;
        end
      end
      SETUP:  state_d = REQ_HI;
      REQ_HI: if (ack_s) state_d = REQ_LO;
      REQ_LO: begin
        if (!ack_s) begin
          if (byte_idx_q == LAST_BYTE) begin
            pop        = 1'b1;
            byte_idx_d = '0;
            state_d    = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            data_d     = pick_byte(head, byte_idx_q + 3'd1, LSB_FIRST);
            state_d    = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    blocks_d = pop ? blocks_q + 16'd1 : blocks_q;
    ovf_d    = drop ? 1'b1 : (i_clr_ovf ? 1'b0 : ovf_q);
  end

  // Handshake outputs are registered from the next state so they change
  // on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      data_q     <= '0;
      req_q      <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      blocks_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      data_q     <= data_d;
      req_q      <= (state_d == REQ_HI);
      last_q     <= (state_d != IDLE) && (byte_idx_d == LAST_BYTE);
      busy_q     <= (state_d != IDLE);
      ovf_q      <= ovf_d;
      blocks_q   <= blocks_d;
    end
  end

`ifdef DES_SER_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk) begin
    if (reset) parity_q <= 1'b1;
    else       parity_q <= ~^data_d;
  end
  assign o_pad_parity = parity_q;
`else
  assign o_pad_parity = 1'b0;
`endif

  assign o_pad_req     = req_q;
  assign o_pad_data    = data_q;
  assign o_pad_last    = last_q;
  assign o_level       = level;
  assign o_busy        = busy_q;
  assign o_overflow    = ovf_q;
  assign o_blocks_sent = blocks_q;

endmodule

// File: tb/tb_des_result_serializer.sv
// Bench for des_result_serializer: two instances (LSB-first and MSB-first),
// each served by a host model; a monitor records {last, parity, byte} at
// every request rise and the tasks compare against an expected-byte queue.
module tb_des_result_serializer;

  localparam int unsigned SYNC       = 2;
  localparam int unsigned ACK_DLY    = 3;
  localparam int unsigned WAIT_LIMIT = 2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        dv_a = 1'b0, clr_a = 1'b0;
  logic [63:0] data_a = '0;
  logic        ack_a, req_a, last_a, par_a, busy_a, ovf_a;
  logic [7:0]  pdata_a;
  logic [1:0]  level_a;
  logic [15:0] sent_a;

  logic        dv_b = 1'b0, clr_b = 1'b0;
  logic [63:0] data_b = '0;
  logic        ack_b = 1'b0, req_b, last_b, par_b, busy_b, ovf_b;
  logic [7:0]  pdata_b;
  logic [1:0]  level_b;
  logic [15:0] sent_b;

  logic man_a = 1'b0, man_ack_a = 1'b0, auto_ack_a = 1'b0, stall_a = 1'b0;
  int   cnt_a = 0, cnt_b = 0;
  logic req_prev_a = 1'b0, req_prev_b = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] exp_sent_a = '0;
  logic [9:0]  exp_a[$], obs_a[$], exp_b[$], obs_b[$];

  always #5 clk = ~clk;
  assign ack_a = man_a ? man_ack_a : auto_ack_a;

  des_result_serializer #(.SYNC_STAGES(SYNC), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .i_dv(dv_a), .i_data(data_a), .i_clr_ovf(clr_a),
    .pad_ack(ack_a), .o_pad_req(req_a), .o_pad_data(pdata_a), .o_pad_last(last_a),
    .o_pad_parity(par_a), .o_level(level_a), .o_busy(busy_a), .o_overflow(ovf_a),
    .o_blocks_sent(sent_a)
  );

  des_result_serializer #(.SYNC_STAGES(SYNC), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .i_dv(dv_b), .i_data(data_b), .i_clr_ovf(clr_b),
    .pad_ack(ack_b), .o_pad_req(req_b), .o_pad_data(pdata_b), .o_pad_last(last_b),
    .o_pad_parity(par_b), .o_level(level_b), .o_busy(busy_b), .o_overflow(ovf_b),
    .o_blocks_sent(sent_b)
  );

  function automatic logic exp_par(input logic [7:0] b);
    logic p;
    p = ~^b;
`ifndef DES_SER_PARITY_EN
    p = 1'b0;
`endif
    return p;
  endfunction

  task automatic push_exp_a(input logic [63:0] d);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = d[8*i +: 8];
      exp_a.push_back({(i == 7), exp_par(b), b});
    end
  endtask

  task automatic push_exp_b(input logic [63:0] d);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = d[8*(7-i) +: 8];
      exp_b.push_back({(i == 7), exp_par(b), b});
    end
  endtask

  // Host models: raise ack ACK_DLY cycles after req rises, drop it once req falls.
  initial forever begin
    @(negedge clk);
    if (man_a) begin
      auto_ack_a = 1'b0;
      cnt_a = 0;
    end else if (!auto_ack_a) begin
      if (req_a && !stall_a) begin
        cnt_a++;
        if (cnt_a >= ACK_DLY) begin
          auto_ack_a = 1'b1;
          cnt_a = 0;
        end
      end else cnt_a = 0;
    end else if (!req_a) auto_ack_a = 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (!ack_b) begin
      if (req_b) begin
        cnt_b++;
        if (cnt_b >= ACK_DLY) begin
          ack_b = 1'b1;
          cnt_b = 0;
        end
      end else cnt_b = 0;
    end else if (!req_b) ack_b = 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (req_a && !req_prev_a) obs_a.push_back({last_a, par_a, pdata_a});
    if (req_b && !req_prev_b) obs_b.push_back({last_b, par_b, pdata_b});
    req_prev_a = req_a;
    req_prev_b = req_b;
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests_run++; if (req_a !== 1'b0) begin tests_failed++; $display("FAIL rst_req: got %b, expected 0", req_a); end
    tests_run++; if (pdata_a !== 8'h00) begin tests_failed++; $display("FAIL rst_data: got %h, expected 00", pdata_a); end
    tests_run++; if (last_a !== 1'b0) begin tests_failed++; $display("FAIL rst_last: got %b, expected 0", last_a); end
    tests_run++; if (par_a !== exp_par(8'h00)) begin tests_failed++; $display("FAIL rst_parity: got %b, expected %b", par_a, exp_par(8'h00)); end
    tests_run++; if (level_a !== 2'd0) begin tests_failed++; $display("FAIL rst_level: got %0d, expected 0", level_a); end
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b, expected 0", busy_a); end
    tests_run++; if (ovf_a !== 1'b0) begin tests_failed++; $display("FAIL rst_ovf: got %b, expected 0", ovf_a); end
    tests_run++; if (sent_a !== 16'd0) begin tests_failed++; $display("FAIL rst_sent: got %0d, expected 0", sent_a); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d7, d8;
    logic [9:0]  got, ex;
    d7 = 64'hFEDC_BA98_7654_3210;
    d8 = 64'h0102_0304_0506_0001;
    @(negedge clk); dv_a = 1'b1; data_a = d7; push_exp_a(d7);
    @(negedge clk); dv_a = 1'b0;
    for (int c = 0; c < WAIT_LIMIT && obs_a.size() < 4; c++) @(negedge clk);
    tests_run++; if (obs_a.size() < 4) begin tests_failed++; $display("FAIL mid_wait: got %0d bytes, expected 4", obs_a.size()); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++; if (req_a !== 1'b0) begin tests_failed++; $display("FAIL mid_req: got %b, expected 0", req_a); end
    tests_run++; if (level_a !== 2'd0) begin tests_failed++; $display("FAIL mid_level: got %0d, expected 0", level_a); end
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %b, expected 0", busy_a); end
    tests_run++; if (sent_a !== exp_sent_a) begin tests_failed++; $display("FAIL mid_sent: got %0d, expected %0d", sent_a, exp_sent_a); end
    tests_run++; if (obs_a.size() != 4) begin tests_failed++; $display("FAIL mid_count: got %0d bytes, expected 4", obs_a.size()); end
    for (int i = 0; i < 4 && obs_a.size() > 0; i++) begin
      got = obs_a.pop_front(); ex = exp_a.pop_front();
      tests_run++; if (got !== ex) begin tests_failed++; $display("FAIL mid_byte%0d: got %h, expected %h", i, got, ex); end
    end
    exp_a.delete(); obs_a.delete();
    repeat (10) @(negedge clk);
    dv_a = 1'b1; data_a = d8; push_exp_a(d8);
    @(negedge clk); dv_a = 1'b0;
    for (int c = 0; c < WAIT_LIMIT && obs_a.size() < 8; c++) @(negedge clk);
    tests_run++; if (obs_a.size() < 8) begin tests_failed++; $display("FAIL mid_next_wait: got %0d bytes, expected 8", obs_a.size()); end
    for (int i = 0; i < 8 && obs_a.size() > 0; i++) begin
      got = obs_a.pop_front(); ex = exp_a.pop_front();
      tests_run++; if (got !== ex) begin tests_failed++; $display("FAIL mid_next_byte%0d: got %h, expected %h", i, got, ex); end
    end
    for (int c = 0; c < WAIT_LIMIT && busy_a !== 1'b0; c++) @(negedge clk);
    exp_sent_a++;
    tests_run++; if (sent_a !== exp_sent_a) begin tests_failed++; $display("FAIL mid_next_sent: got %0d, expected %0d", sent_a, exp_sent_a); end
  endtask

  task automatic test_single();
    logic [63:0] d;
    logic [9:0]  got, ex;
    d = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); dv_a = 1'b1; data_a = d; push_exp_a(d);
    @(negedge clk); dv_a = 1'b0;
    tests_run++; if (level_a !== 2'd1) begin tests_failed++; $display("FAIL single_level_n: got %0d, expected 1", level_a); end
    @(negedge clk);
    tests_run++; if (busy_a !== 1'b1 || req_a !== 1'b0 || pdata_a !== 8'hEF) begin tests_failed++; $display("FAIL single_setup: got busy=%b req=%b data=%h, expected busy=1 req=0 data=ef", busy_a, req_a, pdata_a); end
    @(negedge clk);
    tests_run++; if (req_a !== 1'b1) begin tests_failed++; $display("FAIL single_req_n2: got %b, expected 1", req_a); end
    for (int c = 0; c < WAIT_LIMIT && obs_a.size() < 8; c++) @(negedge clk);
    tests_run++; if (obs_a.size() < 8) begin tests_failed++; $display("FAIL single_wait: got %0d bytes, expected 8", obs_a.size()); end
    for (int i = 0; i < 8 && obs_a.size() > 0; i++) begin
      got = obs_a.pop_front(); ex = exp_a.pop_front();
      tests_run++; if (got !== ex) begin tests_failed++; $display("FAIL single_byte%0d: got %h, expected %h", i, got, ex); end
    end
    for (int c = 0; c < WAIT_LIMIT && busy_a !== 1'b0; c++) @(negedge clk);
    exp_sent_a++;
    tests_run++; if (sent_a !== exp_sent_a) begin tests_failed++; $display("FAIL single_sent: got %0d, expected %0d", sent_a, exp_sent_a); end
    tests_run++; if (level_a !== 2'd0) begin tests_failed++; $display("FAIL single_level_end: got %0d, expected 0", level_a); end
  endtask

  task automatic test_order();
    logic [63:0] d;
    logic [9:0]  got, ex;
    d = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); dv_b = 1'b1; data_b = d; push_exp_b(d);
    @(negedge clk); dv_b = 1'b0;
    for (int c = 0; c < WAIT_LIMIT && obs_b.size() < 8; c++) @(negedge clk);
    tests_run++; if (obs_b.size() < 8) begin tests_failed++; $display("FAIL order_wait: got %0d bytes, expected 8", obs_b.size()); end
    for (int i = 0; i < 8 && obs_b.size() > 0; i++) begin
      got = obs_b.pop_front(); ex = exp_b.pop_front();
      tests_run++; if (got !== ex) begin tests_failed++; $display("FAIL order_byte%0d: got %h, expected %h", i, got, ex); end
    end
    for (int c = 0; c < WAIT_LIMIT && busy_b !== 1'b0; c++) @(negedge clk);
    tests_run++; if (sent_b !== 16'd1) begin tests_failed++; $display("FAIL order_sent: got %0d, expected 1", sent_b); end
    tests_run++; if (level_b !== 2'd0) begin tests_failed++; $display("FAIL order_level: got %0d, expected 0", level_b); end
  endtask

  task automatic test_overflow();
    logic [63:0] d1, d2, d3;
    logic [9:0]  got, ex;
    d1 = 64'h1111_2222_3333_4444;
    d2 = 64'hA5A5_5A5A_C3C3_3C3C;
    d3 = 64'hDEAD_BEEF_CAFE_F00D;
    stall_a = 1'b1;
    @(negedge clk); dv_a = 1'b1; data_a = d1; push_exp_a(d1);
    @(negedge clk); data_a = d2; push_exp_a(d2);
    @(negedge clk); data_a = d3;
    @(negedge clk); dv_a = 1'b0;
    tests_run++; if (level_a !== 2'd2) begin tests_failed++; $display("FAIL ovf_level: got %0d, expected 2", level_a); end
    tests_run++; if (ovf_a !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %b, expected 1", ovf_a); end
    dv_a = 1'b1; data_a = d3; clr_a = 1'b1;
    @(negedge clk); dv_a = 1'b0; clr_a = 1'b0;
    tests_run++; if (ovf_a !== 1'b1) begin tests_failed++; $display("FAIL ovf_set_wins: got %b, expected 1", ovf_a); end
    clr_a = 1'b1;
    @(negedge clk); clr_a = 1'b0;
    tests_run++; if (ovf_a !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %b, expected 0", ovf_a); end
    stall_a = 1'b0;
    for (int c = 0; c < WAIT_LIMIT && obs_a.size() < 16; c++) @(negedge clk);
    tests_run++; if (obs_a.size() < 16) begin tests_failed++; $display("FAIL ovf_wait: got %0d bytes, expected 16", obs_a.size()); end
    for (int i = 0; i < 16 && obs_a.size() > 0; i++) begin
      got = obs_a.pop_front(); ex = exp_a.pop_front();
      tests_run++; if (got !== ex) begin tests_failed++; $display("FAIL ovf_byte%0d: got %h, expected %h", i, got, ex); end
    end
    for (int c = 0; c < WAIT_LIMIT && busy_a !== 1'b0; c++) @(negedge clk);
    exp_sent_a = exp_sent_a + 16'd2;
    tests_run++; if (sent_a !== exp_sent_a) begin tests_failed++; $display("FAIL ovf_sent: got %0d, expected %0d", sent_a, exp_sent_a); end
    tests_run++; if (level_a !== 2'd0) begin tests_failed++; $display("FAIL ovf_level_end: got %0d, expected 0", level_a); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d4, d5, d6;
    logic [9:0]  got, ex;
    logic        ok;
    d4 = 64'h0F1E_2D3C_4B5A_6978;
    d5 = 64'h8877_6655_4433_2211;
    d6 = 64'h13579BDF_2468ACE0;
    ok = 1'b1;
    man_a = 1'b1; man_ack_a = 1'b0;
    @(negedge clk); dv_a = 1'b1; data_a = d4; push_exp_a(d4);
    @(negedge clk); data_a = d5; push_exp_a(d5);
    @(negedge clk); dv_a = 1'b0;
    tests_run++; if (level_a !== 2'd2) begin tests_failed++; $display("FAIL coll_level_pre: got %0d, expected 2", level_a); end
    for (int b = 0; b < 8 && ok; b++) begin
      for (int c = 0; c < WAIT_LIMIT && req_a !== 1'b1; c++) @(negedge clk);
      if (req_a !== 1'b1) begin
        ok = 1'b0; tests_run++; tests_failed++;
        $display("FAIL coll_req_rise%0d: got %b, expected 1", b, req_a);
      end else begin
        man_ack_a = 1'b1;
        for (int c = 0; c < WAIT_LIMIT && req_a !== 1'b0; c++) @(negedge clk);
        if (req_a !== 1'b0) begin
          ok = 1'b0; tests_run++; tests_failed++;
          $display("FAIL coll_req_fall%0d: got %b, expected 0", b, req_a);
        end
        man_ack_a = 1'b0;
      end
    end
    // Ack low reaches the FSM after SYNC edges; the next edge pops byte 7.
    repeat (SYNC) @(negedge clk);
    dv_a = 1'b1; data_a = d6; push_exp_a(d6);
    @(negedge clk); dv_a = 1'b0;
    exp_sent_a++;
    tests_run++; if (level_a !== 2'd2) begin tests_failed++; $display("FAIL coll_level: got %0d, expected 2", level_a); end
    tests_run++; if (ovf_a !== 1'b0) begin tests_failed++; $display("FAIL coll_ovf: got %b, expected 0", ovf_a); end
    tests_run++; if (sent_a !== exp_sent_a) begin tests_failed++; $display("FAIL coll_sent: got %0d, expected %0d", sent_a, exp_sent_a); end
    man_a = 1'b0;
    for (int c = 0; c < WAIT_LIMIT && obs_a.size() < 24; c++) @(negedge clk);
    tests_run++; if (obs_a.size() < 24) begin tests_failed++; $display("FAIL coll_wait: got %0d bytes, expected 24", obs_a.size()); end
    for (int i = 0; i < 24 && obs_a.size() > 0; i++) begin
      got = obs_a.pop_front(); ex = exp_a.pop_front();
      tests_run++; if (got !== ex) begin tests_failed++; $display("FAIL coll_byte%0d: got %h, expected %h", i, got, ex); end
    end
    for (int c = 0; c < WAIT_LIMIT && busy_a !== 1'b0; c++) @(negedge clk);
    exp_sent_a = exp_sent_a + 16'd2;
    tests_run++; if (sent_a !== exp_sent_a) begin tests_failed++; $display("FAIL coll_sent_end: got %0d, expected %0d", sent_a, exp_sent_a); end
    tests_run++; if (level_a !== 2'd0) begin tests_failed++; $display("FAIL coll_level_end: got %0d, expected 0", level_a); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_order();
    test_overflow();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
